// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier arbiter.
//   state_t          controller states (IDLE/ISSUE/WAIT/RESP, fixed encoding)
//   DEF_W            default operand width
//   WD_BITS          width of the WAIT-state watchdog counter
//   timeout_cycles() WAIT cycles allowed before the watchdog fires
// Optional feature macro used by the arbiter: BOOTH_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package booth_pkg;

    localparam int DEF_W   = 16;
    localparam int WD_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    // A Booth pass needs about one cycle per operand bit; 3*W+8 leaves
    // generous headroom before a stuck multiplier is declared dead.
    function automatic int timeout_cycles(input int w);
        return 3 * w + 8;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first requesting index at or
// after the pointer, searching cyclically through NREQ requesters.
// Ports:
//   i_req     per-requester request vector
//   i_ptr     round-robin start index (always < NREQ)
//   o_onehot  one-hot winner (all zero when nothing requests)
//   o_idx     binary index of the winner
//   o_valid   at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IDW-1:0]  o_idx,
    output logic            o_valid
);

    // Pointer plus offset, folded back into 0..NREQ-1 without a divider.
    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= NREQ) ? s - NREQ : s;
    endfunction

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_valid && (((i_req >> wrap_idx(int'(i_ptr), k)) & NREQ'(1)) != '0)) begin
                o_valid  = 1'b1;
                o_idx    = IDW'(wrap_idx(int'(i_ptr), k));
                o_onehot = NREQ'(1) << wrap_idx(int'(i_ptr), k);
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mul_arbiter
// Shares one sequential Booth multiplier among NREQ requesters. A round-robin
// pick in IDLE latches the winner's operands, ISSUE pulses the multiplier start,
// WAIT holds for mul_done (ignored in its first cycle), RESP returns the product
// with a one-cycle strobe and advances the pointer past the owner.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_req           per-requester request, held until its rsp_valid
//   i_opa, i_opb    flattened operands, requester i owns [i*W +: W]
//   o_gnt           one-hot grant, ISSUE through RESP
//   o_rsp_valid     one-hot one-cycle result strobe
//   o_rsp_data      2*W-bit product
//   o_busy          state != IDLE
//   o_mul_start     one-cycle start to the multiplier
//   o_mul_a/o_mul_b latched operands to the multiplier
//   i_mul_done      multiplier done level
//   i_mul_p         multiplier product
//   o_err           (BOOTH_ARB_TIMEOUT_EN only) watchdog expiry, with rsp_valid
// Optional feature macro: BOOTH_ARB_TIMEOUT_EN (WAIT-state watchdog).
// -----------------------------------------------------------------------------
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DEF_W,
    parameter int IDW  = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ*W-1:0]   i_opa,
    input  logic [NREQ*W-1:0]   i_opb,
    output logic [NREQ-1:0]     o_gnt,
    output logic [NREQ-1:0]     o_rsp_valid,
    output logic [2*W-1:0]      o_rsp_data,
    output logic                o_busy,
    output logic                o_mul_start,
    output logic [W-1:0]        o_mul_a,
    output logic [W-1:0]        o_mul_b,
    input  logic                i_mul_done,
`ifdef BOOTH_ARB_TIMEOUT_EN
    output logic                o_err,
`endif
    input  logic [2*W-1:0]      i_mul_p
);

    state_t              r_state;
    state_t              w_next;
    logic [IDW-1:0]      r_owner;
    logic [IDW-1:0]      r_ptr;
    logic [W-1:0]        r_mul_a;
    logic [W-1:0]        r_mul_b;
    logic [2*W-1:0]      r_rsp_data;
    logic                r_wait_first;

    logic [NREQ-1:0]     w_win_onehot;
    logic [IDW-1:0]      w_win_idx;
    logic                w_win_valid;
    logic [W-1:0]        w_sel_a;
    logic [W-1:0]        w_sel_b;
    logic [NREQ-1:0]     w_owner_onehot;
    logic                w_done_ok;
    logic                w_timeout;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    // AND-OR operand mux driven by the one-hot winner.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_onehot[i]) begin
                w_sel_a = w_sel_a | i_opa[i*W +: W];
                w_sel_b = w_sel_b | i_opb[i*W +: W];
            end
        end
    end

    assign w_owner_onehot = NREQ'(1) << r_owner;

    // The first WAIT cycle covers the multiplier's start-to-busy latency, where
    // a stale done from the previous operation may still be visible.
    assign w_done_ok = (r_state == WAIT) && !r_wait_first && i_mul_done;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(timeout_cycles(W) - 1);

    logic [WD_BITS-1:0] r_wd_cnt;
    logic               r_to_flag;

    assign w_timeout = (r_state == WAIT) && !w_done_ok && (r_wd_cnt == WD_LAST);
    assign o_err     = (r_state == RESP) && r_to_flag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_wd_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (r_state == WAIT) begin
                r_to_flag <= w_timeout;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_mul_start = 1'b0;
        o_gnt       = '0;
        o_rsp_valid = '0;
        o_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                o_mul_start = 1'b1;
                o_gnt       = w_owner_onehot;
                o_busy      = 1'b1;
                w_next      = WAIT;
            end
            WAIT: begin
                o_gnt  = w_owner_onehot;
                o_busy = 1'b1;
                if (w_done_ok || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                o_gnt       = w_owner_onehot;
                o_rsp_valid = w_owner_onehot;
                o_busy      = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr        <= '0;
            r_owner      <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_rsp_data   <= '0;
            r_wait_first <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_owner <= w_win_idx;
                        r_mul_a <= w_sel_a;
                        r_mul_b <= w_sel_b;
                    end
                end
                ISSUE: r_wait_first <= 1'b1;
                WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_done_ok) begin
                        r_rsp_data <= i_mul_p;
                    end else if (w_timeout) begin
                        r_rsp_data <= '1;
                    end
                end
                RESP: r_ptr <= (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                default: ;
            endcase
        end
    end

    assign o_mul_a    = r_mul_a;
    assign o_mul_b    = r_mul_b;
    assign o_rsp_data = r_rsp_data;

endmodule
